// File: rtl/pll_clk_sequencer_if.sv
// Signal bundle between the PLL sequencer and the PLL / downstream clock domain.
// master = sequencer side, slave = PLL / status side.
interface pll_clk_sequencer_if #(
   parameter int NUM_CLK = 5
);
   logic               pll_lock;
   logic               sw_restart;
   logic               pll_reset;
   logic [NUM_CLK-1:0] enclk;
   logic               domain_rstn;
   logic               ready;
   logic [2:0]         state;
   logic [7:0]         lock_lost_cnt;

   modport master (
      input  pll_lock, sw_restart,
      output pll_reset, enclk, domain_rstn, ready, state, lock_lost_cnt
   );

   modport slave (
      output pll_lock, sw_restart,
      input  pll_reset, enclk, domain_rstn, ready, state, lock_lost_cnt
   );
endinterface

// File: rtl/pll_clk_sequencer.sv
// PLL power-up / recovery sequencer: PLL reset, lock filter, staged clock-gate enables, domain reset release.
// Define PLL_SEQ_TIMEOUT_EN to build the WAIT_LOCK timeout (re-resets the PLL after TIMEOUT cycles).
//
// state     | meaning
// ----------+--------------------------------------------------
// RESET_PLL | pll_reset asserted for RST_HOLD cycles
// WAIT_LOCK | waiting for LOCK_FILTER consecutive synced lock=1
// ENABLE    | opening one enclk bit every STAGE_GAP cycles
// RELEASE   | all clocks on, domain reset held RST_HOLD cycles
// RUN       | steady state, domain out of reset, ready=1
module pll_clk_sequencer #(
   parameter int NUM_CLK     = 5,
   parameter int LOCK_FILTER = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int RST_HOLD    = 32
`ifdef PLL_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT     = 65535
`endif
) (
   input  logic                clk,
   input  logic                resetn,
   pll_clk_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      ENABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam int FILT_W = $clog2(LOCK_FILTER + 1);
   localparam int GAP_W  = $clog2(STAGE_GAP + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

   state_t             state_q, state_nxt;
   logic [HOLD_W-1:0]  hold_q, hold_nxt;
   logic [FILT_W-1:0]  filt_q, filt_nxt;
   logic [GAP_W-1:0]   gap_q, gap_nxt;
   logic [NUM_CLK-1:0] enclk_q, enclk_nxt;
   logic               pll_reset_q, pll_reset_nxt;
   logic               domain_rstn_q, domain_rstn_nxt;
   logic               ready_q, ready_nxt;
   logic [7:0]         lost_q, lost_nxt;
   logic               lock_m, lock_s;
   logic               lock_loss;
   logic               teardown;

`ifdef PLL_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0]    to_q, to_nxt;
`endif

   // pll_lock is asynchronous to the reference clock
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= bus.pll_lock;
         lock_s <= lock_m;
      end
   end

   assign lock_loss = !lock_s && (state_q == ENABLE || state_q == RELEASE || state_q == RUN);
   assign teardown  = lock_loss || bus.sw_restart;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RESET_PLL;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state_q;
      hold_nxt        = hold_q;
      filt_nxt        = filt_q;
      gap_nxt         = gap_q;
      enclk_nxt       = enclk_q;
      pll_reset_nxt   = pll_reset_q;
      domain_rstn_nxt = domain_rstn_q;
      ready_nxt       = ready_q;
      lost_nxt        = lost_q;
`ifdef PLL_SEQ_TIMEOUT_EN
      to_nxt          = to_q;
`endif

      if (teardown) begin
         // a restart coinciding with a loss is still recorded as a loss
         state_nxt       = RESET_PLL;
         hold_nxt        = '0;
         filt_nxt        = '0;
         gap_nxt         = '0;
         enclk_nxt       = '0;
         pll_reset_nxt   = 1'b1;
         domain_rstn_nxt = 1'b0;
         ready_nxt       = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
         to_nxt          = '0;
`endif
         if (lock_loss && lost_q != 8'hFF) begin
            lost_nxt = lost_q + 8'd1;
         end
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (hold_q == HOLD_LAST) begin
                  state_nxt     = WAIT_LOCK;
                  pll_reset_nxt = 1'b0;
                  hold_nxt      = '0;
                  filt_nxt      = '0;
`ifdef PLL_SEQ_TIMEOUT_EN
                  to_nxt        = '0;
`endif
               end else begin
                  hold_nxt = hold_q + HOLD_W'(1);
               end
            end

            WAIT_LOCK: begin
               filt_nxt = lock_s ? filt_q + FILT_W'(1) : '0;
               if (lock_s && filt_q == FILT_LAST) begin
                  state_nxt = ENABLE;
                  enclk_nxt = NUM_CLK'(1);
                  gap_nxt   = '0;
               end
`ifdef PLL_SEQ_TIMEOUT_EN
               else if (to_q == TO_LAST) begin
                  state_nxt     = RESET_PLL;
                  pll_reset_nxt = 1'b1;
                  hold_nxt      = '0;
               end else begin
                  to_nxt = to_q + TO_W'(1);
               end
`endif
            end

            ENABLE: begin
               if (gap_q == GAP_LAST) begin
                  gap_nxt = '0;
                  if (enclk_q[NUM_CLK-1]) begin
                     state_nxt = RELEASE;
                     hold_nxt  = '0;
                  end else begin
                     enclk_nxt = (enclk_q << 1) | NUM_CLK'(1);
                  end
               end else begin
                  gap_nxt = gap_q + GAP_W'(1);
               end
            end

            RELEASE: begin
               if (hold_q == HOLD_LAST) begin
                  state_nxt       = RUN;
                  domain_rstn_nxt = 1'b1;
                  ready_nxt       = 1'b1;
               end else begin
                  hold_nxt = hold_q + HOLD_W'(1);
               end
            end

            RUN: begin
               state_nxt = RUN;
            end

            default: begin
               state_nxt     = RESET_PLL;
               hold_nxt      = '0;
               enclk_nxt     = '0;
               pll_reset_nxt = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_q        <= '0;
         filt_q        <= '0;
         gap_q         <= '0;
         enclk_q       <= '0;
         pll_reset_q   <= 1'b1;
         domain_rstn_q <= 1'b0;
         ready_q       <= 1'b0;
         lost_q        <= '0;
`ifdef PLL_SEQ_TIMEOUT_EN
         to_q          <= '0;
`endif
      end else begin
         hold_q        <= hold_nxt;
         filt_q        <= filt_nxt;
         gap_q         <= gap_nxt;
         enclk_q       <= enclk_nxt;
         pll_reset_q   <= pll_reset_nxt;
         domain_rstn_q <= domain_rstn_nxt;
         ready_q       <= ready_nxt;
         lost_q        <= lost_nxt;
`ifdef PLL_SEQ_TIMEOUT_EN
         to_q          <= to_nxt;
`endif
      end
   end

   assign bus.pll_reset     = pll_reset_q;
   assign bus.enclk         = enclk_q;
   assign bus.domain_rstn   = domain_rstn_q;
   assign bus.ready         = ready_q;
   assign bus.state         = state_q;
   assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Directed bench for pll_clk_sequencer (NUM_CLK=5, LOCK_FILTER=8, STAGE_GAP=4, RST_HOLD=4, TIMEOUT=64).
// Build with PLL_SEQ_TIMEOUT_EN defined to exercise the WAIT_LOCK timeout branch.
module tb_pll_clk_sequencer;

   logic clk = 1'b0;
   logic resetn;
   int   n_tests = 0;
   int   n_fail  = 0;

   pll_clk_sequencer_if #(.NUM_CLK(5)) bus ();

   pll_clk_sequencer #(
      .NUM_CLK    (5),
      .LOCK_FILTER(8),
      .STAGE_GAP  (4),
      .RST_HOLD   (4)
`ifdef PLL_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT    (64)
`endif
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string p);
      chk({p, "_state"},  bus.state,         32'd0);
      chk({p, "_pllrst"}, bus.pll_reset,     32'd1);
      chk({p, "_enclk"},  bus.enclk,         32'd0);
      chk({p, "_drstn"},  bus.domain_rstn,   32'd0);
      chk({p, "_ready"},  bus.ready,         32'd0);
      chk({p, "_cnt"},    bus.lock_lost_cnt, 32'd0);
   endtask

   // Starts just after the edge that put the DUT in RESET_PLL with its hold count at 0, lock held high.
   task automatic run_sequence(input string p);
      tick(3);
      chk({p, "_rst_last"},  bus.pll_reset, 32'd1);
      chk({p, "_st_rst"},    bus.state,     32'd0);
      tick(1);
      chk({p, "_rst_off"},   bus.pll_reset, 32'd0);
      chk({p, "_st_wait"},   bus.state,     32'd1);
      tick(7);
      chk({p, "_st_wait7"},  bus.state,     32'd1);
      tick(1);
      chk({p, "_st_en"},     bus.state,     32'd2);
      chk({p, "_enclk0"},    bus.enclk,     32'h01);
      for (int i = 1; i < 5; i++) begin
         tick(3);
         chk({p, "_enclk_hold"}, bus.enclk, 32'((1 << i) - 1));
         tick(1);
         chk({p, "_enclk_step"}, bus.enclk, 32'((1 << (i + 1)) - 1));
      end
      tick(4);
      chk({p, "_st_rel"},    bus.state,       32'd3);
      tick(3);
      chk({p, "_drstn_hold"}, bus.domain_rstn, 32'd0);
      chk({p, "_ready_hold"}, bus.ready,       32'd0);
      tick(1);
      chk({p, "_st_run"},    bus.state,       32'd4);
      chk({p, "_drstn_run"}, bus.domain_rstn, 32'd1);
      chk({p, "_ready_run"}, bus.ready,       32'd1);
      chk({p, "_enclk_run"}, bus.enclk,       32'h1f);
      chk({p, "_pllrst_run"}, bus.pll_reset,  32'd0);
   endtask

   task automatic wait_state(input logic [2:0] s, input int max, input string tag);
      int g = 0;
      while (bus.state !== s && g < max) begin
         tick(1);
         g++;
      end
      chk(tag, bus.state, s);
   endtask

   task automatic pulse_restart();
      bus.sw_restart = 1'b1;
      tick(1);
      bus.sw_restart = 1'b0;
   endtask

   initial begin
      resetn         = 1'b0;
      bus.pll_lock   = 1'b1;
      bus.sw_restart = 1'b0;
      tick(3);
      check_reset("rst");

      // power-up with lock already present
      resetn = 1'b1;
      run_sequence("seq1");

      // one-cycle lock drop in RUN: teardown three edges later
      bus.pll_lock = 1'b0;
      tick(1);
      bus.pll_lock = 1'b1;
      tick(1);
      chk("loss_pre_state", bus.state, 32'd4);
      tick(1);
      chk("loss_state",  bus.state,         32'd0);
      chk("loss_enclk",  bus.enclk,         32'd0);
      chk("loss_drstn",  bus.domain_rstn,   32'd0);
      chk("loss_ready",  bus.ready,         32'd0);
      chk("loss_pllrst", bus.pll_reset,     32'd1);
      chk("loss_cnt",    bus.lock_lost_cnt, 32'd1);
      run_sequence("seq2");

      // software restart from RUN, then again mid-ENABLE at enclk=00011
      pulse_restart();
      chk("swr_run_state", bus.state,         32'd0);
      chk("swr_run_cnt",   bus.lock_lost_cnt, 32'd1);
      tick(12);
      chk("swr_en_state", bus.state, 32'd2);
      tick(4);
      chk("swr_en_enclk_pre", bus.enclk, 32'h03);
      pulse_restart();
      chk("swr_en_enclk",  bus.enclk,         32'd0);
      chk("swr_en_state",  bus.state,         32'd0);
      chk("swr_en_cnt",    bus.lock_lost_cnt, 32'd1);
      chk("swr_en_pllrst", bus.pll_reset,     32'd1);

      // restart coinciding with a lock loss counts as a loss
      wait_state(3'd2, 20, "sim_wait_enable");
      bus.pll_lock = 1'b0;
      tick(1);
      bus.pll_lock = 1'b1;
      tick(1);
      bus.sw_restart = 1'b1;
      tick(1);
      bus.sw_restart = 1'b0;
      chk("sim_state", bus.state,         32'd0);
      chk("sim_cnt",   bus.lock_lost_cnt, 32'd2);

      // restart inside RESET_PLL restarts the hold count
      tick(2);
      pulse_restart();
      tick(3);
      chk("rsthold_restart_st", bus.state,     32'd0);
      chk("rsthold_restart_pr", bus.pll_reset, 32'd1);
      tick(1);
      chk("rsthold_restart_wait", bus.state, 32'd1);

      // lock glitch during WAIT_LOCK only restarts the filter
      resetn       = 1'b0;
      bus.pll_lock = 1'b0;
      tick(1);
      resetn = 1'b1;
      tick(4);
      chk("glitch_wait", bus.state, 32'd1);
      bus.pll_lock = 1'b1;
      tick(5);
      bus.pll_lock = 1'b0;
      tick(1);
      bus.pll_lock = 1'b1;
      chk("glitch_still_wait", bus.state, 32'd1);
      tick(9);
      chk("glitch_wait9", bus.state, 32'd1);
      tick(1);
      chk("glitch_enable", bus.state,         32'd2);
      chk("glitch_cnt",    bus.lock_lost_cnt, 32'd0);

      // lock never arrives
      resetn       = 1'b0;
      bus.pll_lock = 1'b0;
      tick(1);
      resetn = 1'b1;
      tick(4);
      chk("nolock_wait", bus.state, 32'd1);
`ifdef PLL_SEQ_TIMEOUT_EN
      tick(63);
      chk("to_wait63", bus.state, 32'd1);
      tick(1);
      chk("to_reset",  bus.state,     32'd0);
      chk("to_pllrst", bus.pll_reset, 32'd1);
      tick(4);
      chk("to_rewait", bus.state, 32'd1);
      tick(63);
      chk("to_rewait63", bus.state, 32'd1);
      tick(1);
      chk("to_reset2", bus.state,         32'd0);
      chk("to_cnt",    bus.lock_lost_cnt, 32'd0);
`else
      tick(200);
      chk("nolock_state",  bus.state,     32'd1);
      chk("nolock_pllrst", bus.pll_reset, 32'd0);
      chk("nolock_enclk",  bus.enclk,     32'd0);
`endif

      // 256 lock losses: counter saturates at 255
      bus.pll_lock = 1'b1;
      for (int i = 0; i < 256; i++) begin
         wait_state(3'd2, 40, "sat_wait_enable");
         bus.pll_lock = 1'b0;
         tick(1);
         bus.pll_lock = 1'b1;
         tick(2);
         if (i == 199) chk("cnt_200", bus.lock_lost_cnt, 32'd200);
      end
      chk("cnt_sat",       bus.lock_lost_cnt, 32'd255);
      chk("cnt_sat_state", bus.state,         32'd0);

      // async reset mid-ENABLE takes effect without a clock edge
      wait_state(3'd2, 40, "mid_wait_enable");
      tick(4);
      chk("mid_enclk", bus.enclk, 32'h03);
      #2;
      resetn = 1'b0;
      #1;
      check_reset("async");
      tick(1);
      resetn = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
